// File: rtl/spi_param_ctrl.sv
// Word-level command sequencer between the SPI word serdes and the parameter memory host port.
// Define SPI_PARAM_CTRL_AUTOINC_EN to step the address after every write and every read fetch.
module spi_param_ctrl #(
  parameter int PARAM_WIDTH = 8,
  parameter int ADDR_WIDTH  = 7,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   frame_active,
  input  logic                   rx_valid,
  input  logic [PARAM_WIDTH-1:0] rx_data,
  output logic                   tx_load,
  output logic [PARAM_WIDTH-1:0] tx_data,
  output logic                   mem_we,
  output logic [ADDR_WIDTH-1:0]  mem_waddr,
  output logic [PARAM_WIDTH-1:0] mem_wdata,
  output logic [ADDR_WIDTH-1:0]  mem_raddr,
  input  logic [PARAM_WIDTH-1:0] mem_rdata,
  output logic                   frame_done,
  output logic [COUNT_WIDTH-1:0] word_count,
  output logic                   err_overrun
);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WR,
    RD_F0,
    RD_F1,
    RD_F2,
    RD_WAIT
  } state_e;

  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d, addr_next;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [COUNT_WIDTH-1:0] word_count_q, word_count_d;
  logic                   we_q, we_d;
  logic [ADDR_WIDTH-1:0]  waddr_q, waddr_d;
  logic [PARAM_WIDTH-1:0] wdata_q, wdata_d;
  logic                   tx_load_q, tx_load_d;
  logic [PARAM_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                   frame_done_q, frame_done_d;
  logic                   err_q, err_d;

`ifdef SPI_PARAM_CTRL_AUTOINC_EN
  assign addr_next = addr_q + 1'b1;
`else
  assign addr_next = addr_q;
`endif

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can leave it unassigned and infer a latch.
    state_d      = state_q;
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    word_count_d = word_count_q;
    we_d         = 1'b0;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    tx_load_d    = 1'b0;
    tx_data_d    = tx_data_q;
    frame_done_d = 1'b0;
    err_d        = err_q;

    if (rx_valid && (state_q != IDLE) && (cnt_q != CNT_MAX)) cnt_d = cnt_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (frame_active) begin
          state_d = CMD;
          cnt_d   = '0;
        end
      end
      CMD: begin
        if (rx_valid) begin
          addr_d  = rx_data[ADDR_WIDTH-1:0];
          state_d = rx_data[PARAM_WIDTH-1] ? RD_F0 : WR;
        end
      end
      WR: begin
        if (rx_valid) begin
          we_d    = 1'b1;
          waddr_d = addr_q;
          wdata_d = rx_data;
          addr_d  = addr_next;
        end
      end
      // mem_raddr follows addr_q, so F0 presents the address and F1 sees the data.
      RD_F0: state_d = RD_F1;
      RD_F1: begin
        tx_data_d = mem_rdata;
        tx_load_d = 1'b1;
        state_d   = RD_F2;
      end
      RD_F2: begin
        addr_d  = addr_next;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (rx_valid) state_d = RD_F0;
      end
      default: state_d = IDLE;
    endcase

    if (rx_valid && ((state_q == RD_F0) || (state_q == RD_F1) || (state_q == RD_F2))) err_d = 1'b1;

    // Frame end wins over everything except a write already issued this cycle.
    if ((state_q != IDLE) && !frame_active) begin
      state_d      = IDLE;
      tx_load_d    = 1'b0;
      frame_done_d = 1'b1;
      word_count_d = cnt_d;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      cnt_q        <= '0;
      word_count_q <= '0;
      we_q         <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      tx_load_q    <= 1'b0;
      tx_data_q    <= '0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      word_count_q <= word_count_d;
      we_q         <= we_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      tx_load_q    <= tx_load_d;
      tx_data_q    <= tx_data_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
    end
  end

  assign tx_load     = tx_load_q;
  assign tx_data     = tx_data_q;
  assign mem_we      = we_q;
  assign mem_waddr   = waddr_q;
  assign mem_wdata   = wdata_q;
  assign mem_raddr   = addr_q;
  assign frame_done  = frame_done_q;
  assign word_count  = word_count_q;
  assign err_overrun = err_q;

endmodule

// File: tb/tb_spi_param_ctrl.sv
// Self-checking bench for spi_param_ctrl: directed frames plus random bursts against a frame-level model.
module tb_spi_param_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_active;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       tx_load;
  logic [7:0] tx_data;
  logic       mem_we;
  logic [6:0] mem_waddr;
  logic [7:0] mem_wdata;
  logic [6:0] mem_raddr;
  logic [7:0] mem_rdata;
  logic       frame_done;
  logic [7:0] word_count;
  logic       err_overrun;

`ifdef SPI_PARAM_CTRL_AUTOINC_EN
  localparam int INC = 1;
`else
  localparam int INC = 0;
`endif

  spi_param_ctrl #(.PARAM_WIDTH(8), .ADDR_WIDTH(7), .COUNT_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .frame_active(frame_active), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_load(tx_load), .tx_data(tx_data), .mem_we(mem_we), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .frame_done(frame_done), .word_count(word_count), .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  // Parameter memory with a 1-cycle registered read and a bench-side preload port.
  logic [7:0] mem [128];
  logic       pre_we = 1'b0;
  logic [6:0] pre_a  = '0;
  logic [7:0] pre_d  = '0;
  always @(posedge clk) begin
    if (pre_we) mem[pre_a] <= pre_d;
    else if (mem_we) mem[mem_waddr] <= mem_wdata;
    mem_rdata <= mem[mem_raddr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: everything the DUT emits, sampled mid-cycle.
  int         mon_wa[$];
  int         mon_wd[$];
  int         mon_tx_cyc[$];
  int         mon_tx_data[$];
  int         done_cnt = 0;
  always @(negedge clk) begin
    if (mem_we) begin
      mon_wa.push_back(int'(mem_waddr));
      mon_wd.push_back(int'(mem_wdata));
    end
    if (tx_load) begin
      mon_tx_cyc.push_back(cyc);
      mon_tx_data.push_back(int'(tx_data));
    end
    if (frame_done) done_cnt = done_cnt + 1;
  end

  logic [7:0] ref_mem [128];
  logic [7:0] fw[$];
  int         rx_cyc[$];
  int         n_pass = 0;
  int         n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic clear_mon();
    mon_wa.delete(); mon_wd.delete(); mon_tx_cyc.delete(); mon_tx_data.delete();
    rx_cyc.delete();
    done_cnt = 0;
  endtask

  task automatic preload(input int a, input logic [7:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_a = 7'(a); pre_d = d;
    ref_mem[a] = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w, input int gap);
    rx_data  = w;
    rx_valid = 1'b1;
    rx_cyc.push_back(cyc);
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = '0;
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic wait_done(input string tag);
    bit seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      #1;
      if (done_cnt != 0) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  // Frame in fw[]: command word then data/dummy words. Model computed from the frame rules.
  task automatic run_frame(input string tag, input int gap);
    int         n  = fw.size();
    bit         rd = fw[0][7];
    int         a0 = int'(fw[0][6:0]);
    int         exp_wa[$];
    int         exp_wd[$];
    int         exp_rd[$];
    if (rd) begin
      for (int i = 0; i < n; i++) exp_rd.push_back(int'(ref_mem[(a0 + INC * i) % 128]));
    end else begin
      for (int i = 1; i < n; i++) begin
        int a = (a0 + INC * (i - 1)) % 128;
        exp_wa.push_back(a);
        exp_wd.push_back(int'(fw[i]));
        ref_mem[a] = fw[i];
      end
    end
    @(negedge clk);
    frame_active = 1'b1;
    repeat (2) @(negedge clk);
    clear_mon();
    for (int i = 0; i < n; i++) send_word(fw[i], gap);
    frame_active = 1'b0;
    wait_done(tag);
    repeat (2) @(negedge clk);
    check({tag, "_word_count"}, 32'(word_count), 32'(n));
    check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    check({tag, "_n_writes"}, 32'(mon_wa.size()), 32'(exp_wa.size()));
    check({tag, "_n_tx"}, 32'(mon_tx_data.size()), 32'(exp_rd.size()));
    for (int i = 0; i < exp_wa.size() && i < mon_wa.size(); i++) begin
      check($sformatf("%s_waddr%0d", tag, i), 32'(mon_wa[i]), 32'(exp_wa[i]));
      check($sformatf("%s_wdata%0d", tag, i), 32'(mon_wd[i]), 32'(exp_wd[i]));
    end
    for (int i = 0; i < exp_rd.size() && i < mon_tx_data.size(); i++) begin
      check($sformatf("%s_txdata%0d", tag, i), 32'(mon_tx_data[i]), 32'(exp_rd[i]));
      check($sformatf("%s_txlat%0d", tag, i), 32'(mon_tx_cyc[i]), 32'(rx_cyc[i] + 3));
    end
  endtask

  initial begin
    rst = 1'b1; frame_active = 1'b0; rx_valid = 1'b0; rx_data = '0;
    for (int i = 0; i < 128; i++) preload(i, 8'($urandom));
    check("rst_tx_load", 32'(tx_load), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_waddr", 32'(mem_waddr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_mem_raddr", 32'(mem_raddr), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_word_count", 32'(word_count), 32'd0);
    check("rst_err", 32'(err_overrun), 32'd0);
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);

    fw = '{8'h05, 8'hAA, 8'hBB, 8'hCC};
    run_frame("wr_burst", 34);

    preload(8'h10, 8'h11);
    preload(8'h11, 8'h22);
    fw = '{8'h90, 8'h00, 8'h00};
    run_frame("rd_burst", 33);

    fw = '{8'h7F, 8'h01, 8'h02};
    run_frame("wrap", 32);

    // Fetch abandoned when the frame closes one cycle after the read command.
    @(negedge clk); frame_active = 1'b1;
    repeat (2) @(negedge clk);
    clear_mon();
    rx_data = 8'hA3; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0; rx_data = '0; frame_active = 1'b0;
    @(negedge clk);
    check("abort_frame_done", 32'(frame_done), 32'd1);
    check("abort_word_count", 32'(word_count), 32'd1);
    repeat (8) @(negedge clk);
    check("abort_no_tx", 32'(mon_tx_data.size()), 32'd0);
    check("abort_done_cnt", 32'(done_cnt), 32'd1);

    // A word arriving during the fetch: counted, flagged, fetch still completes.
    @(negedge clk); frame_active = 1'b1;
    repeat (2) @(negedge clk);
    clear_mon();
    rx_cyc.push_back(cyc);
    rx_data = 8'hC4; rx_valid = 1'b1;
    @(negedge clk);
    rx_data = 8'h00;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (36) @(negedge clk);
    check("ovr_err", 32'(err_overrun), 32'd1);
    check("ovr_n_tx", 32'(mon_tx_data.size()), 32'd1);
    if (mon_tx_data.size() > 0) begin
      check("ovr_txdata", 32'(mon_tx_data[0]), 32'(ref_mem[8'h44]));
      check("ovr_txlat", 32'(mon_tx_cyc[0]), 32'(rx_cyc[0] + 3));
    end
    frame_active = 1'b0;
    wait_done("ovr");
    check("ovr_word_count", 32'(word_count), 32'd2);

    for (int f = 0; f < 10; f++) begin
      logic [6:0] a  = (f % 3 == 0) ? 7'(7'h7D + f) : 7'($urandom);
      bit         rw = 1'($urandom_range(0, 1));
      int         n  = $urandom_range(2, 6);
      fw = '{};
      fw.push_back({rw, a});
      for (int i = 1; i < n; i++) fw.push_back(8'($urandom));
      run_frame($sformatf("rand%0d", f), $urandom_range(32, 40));
      check($sformatf("rand%0d_err_sticky", f), 32'(err_overrun), 32'd1);
    end

    // Asynchronous reset landing in the middle of a registered write.
    @(negedge clk); frame_active = 1'b1;
    repeat (2) @(negedge clk);
    send_word(8'h20, 32);
    send_word(8'h5A, 1);
    check("arst_we_pending", 32'(mem_we), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_mem_we", 32'(mem_we), 32'd0);
    check("arst_tx_load", 32'(tx_load), 32'd0);
    check("arst_waddr", 32'(mem_waddr), 32'd0);
    check("arst_wdata", 32'(mem_wdata), 32'd0);
    check("arst_word_count", 32'(word_count), 32'd0);
    check("arst_err", 32'(err_overrun), 32'd0);
    clear_mon();
    @(negedge clk);
    send_word(8'h66, 4);
    frame_active = 1'b0;
    check("arst_no_write", 32'(mon_wa.size()), 32'd0);
    check("arst_mem_kept", 32'(mem[8'h20]), 32'(ref_mem[8'h20]));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    fw = '{8'h33, 8'h9E, 8'h4D};
    run_frame("post_rst_wr", 32);
    fw = '{8'hB3, 8'h00, 8'h00};
    run_frame("post_rst_rd", 35);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
